// File: rtl/ps2_tx_if.sv
// Host-side and pad-side signals of the PS/2 transmitter.
// The master drives the command strobe and returns the resolved pad values.
interface ps2_tx_if;
    logic       wr_ps2;
    logic [7:0] din;
    logic       ps2c_in;
    logic       ps2d_in;
    logic       ps2c_out;
    logic       ps2d_out;
    logic       tri_c;
    logic       tri_d;
    logic       tx_idle;
    logic       tx_done_tick;

    modport master (
        output wr_ps2, din, ps2c_in, ps2d_in,
        input  ps2c_out, ps2d_out, tri_c, tri_d, tx_idle, tx_done_tick
    );

    modport slave (
        input  wr_ps2, din, ps2c_in, ps2d_in,
        output ps2c_out, ps2d_out, tri_c, tri_d, tx_idle, tx_done_tick
    );
endinterface

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, then start, 8 data bits
// LSB-first and odd parity, clocked by falling edges of the device clock.
module ps2_tx #(
    parameter int RTS_CYCLES = 10000,
    parameter int FILTER_LEN = 8
) (
    input logic     clk,
    input logic     reset,
    ps2_tx_if.slave bus
);
    localparam int CW = $clog2(RTS_CYCLES);

    typedef enum logic [2:0] {IDLE, RTS, START, DATA, STOP} state_t;

    state_t                state_reg, state_next;
    logic [FILTER_LEN-1:0] filter_reg;
    logic                  f_ps2c_reg, f_ps2c_next;
    logic                  fall_edge;
    logic [CW-1:0]         c_reg, c_next;
    logic [3:0]            n_reg, n_next;
    logic [8:0]            b_reg, b_next;
    logic                  unused_ps2d;

    assign unused_ps2d = bus.ps2d_in;

    // Filtered clock only moves on a unanimous window, so short glitches are absorbed.
    always_comb begin
        f_ps2c_next = f_ps2c_reg;
        if (&filter_reg)
            f_ps2c_next = 1'b1;
        else if (~|filter_reg)
            f_ps2c_next = 1'b0;
    end

    assign fall_edge = f_ps2c_reg & ~f_ps2c_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            filter_reg <= '0;
            f_ps2c_reg <= 1'b0;
            state_reg  <= IDLE;
            c_reg      <= '0;
            n_reg      <= '0;
            b_reg      <= '0;
        end else begin
            filter_reg <= {bus.ps2c_in, filter_reg[FILTER_LEN-1:1]};
            f_ps2c_reg <= f_ps2c_next;
            state_reg  <= state_next;
            c_reg      <= c_next;
            n_reg      <= n_next;
            b_reg      <= b_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        c_next           = c_reg;
        n_next           = n_reg;
        b_next           = b_reg;
        bus.tri_c        = 1'b0;
        bus.tri_d        = 1'b0;
        bus.ps2c_out     = 1'b0;
        bus.ps2d_out     = 1'b0;
        bus.tx_idle      = 1'b0;
        bus.tx_done_tick = 1'b0;
        unique case (state_reg)
            IDLE: begin
                bus.tx_idle = 1'b1;
                if (bus.wr_ps2) begin
                    b_next     = {~^bus.din, bus.din};
                    c_next     = CW'(RTS_CYCLES - 1);
                    state_next = RTS;
                end
            end
            RTS: begin
                bus.tri_c = 1'b1;
                if (c_reg == '0)
                    state_next = START;
                else
                    c_next = c_reg - 1'b1;
            end
            START: begin
                bus.tri_d = 1'b1;
                if (fall_edge) begin
                    n_next     = 4'd8;
                    state_next = DATA;
                end
            end
            DATA: begin
                bus.tri_d    = 1'b1;
                bus.ps2d_out = b_reg[0];
                if (fall_edge) begin
                    b_next = {1'b0, b_reg[8:1]};
                    if (n_reg == 4'd0)
                        state_next = STOP;
                    else
                        n_next = n_reg - 1'b1;
                end
            end
            STOP: begin
                // Data released: the pull-up supplies the stop bit.
                if (fall_edge) begin
                    bus.tx_done_tick = 1'b1;
                    state_next       = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: a device model clocks frames out and compares them
// against a queue of hand-computed {parity, byte} entries.
module tb_ps2_tx;
    localparam int RTS  = 16;
    localparam int FL   = 4;
    localparam int HALF = 20;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ps2_tx_if tif();

    ps2_tx #(.RTS_CYCLES(RTS), .FILTER_LEN(FL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (tif)
    );

    logic dev_clk   = 1'b1;
    logic glitch_lo = 1'b0;
    logic dev_abort = 1'b0;
    int   dev_falls = 0;
    int   done_cnt  = 0;
    int   n_cmp     = 0;
    int   n_err     = 0;
    logic [8:0] exp_q[$];
    logic ps2d_line;

    // Open-collector lines: wired-AND of every driver, pulled high otherwise.
    assign ps2d_line   = tif.tri_d ? tif.ps2d_out : 1'b1;
    assign tif.ps2c_in = dev_clk & ~glitch_lo & ~(tif.tri_c & ~tif.ps2c_out);
    assign tif.ps2d_in = ps2d_line;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic dev_wait(input int n, output bit ab);
        ab = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (dev_abort) begin
                ab = 1'b1;
                return;
            end
        end
    endtask

    // Device side: 11 clock pulses, data read while the clock is high.
    task automatic run_frame();
        logic [9:0] bits;
        logic [8:0] e;
        bit ab;
        bits = '0;
        dev_falls = 0;
        dev_wait(100, ab);
        if (ab) return;
        for (int k = 0; k < 11; k++) begin
            dev_clk = 1'b0;
            dev_falls++;
            dev_wait(HALF, ab);
            if (ab) begin
                dev_clk = 1'b1;
                return;
            end
            dev_clk = 1'b1;
            if (k < 10) bits[k] = ps2d_line;
            dev_wait(HALF, ab);
            if (ab) return;
        end
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL frame_unexpected: got 0x%0h, expected no frame", bits);
        end else begin
            e = exp_q.pop_front();
            chk("frame_data", {24'd0, bits[7:0]}, {24'd0, e[7:0]});
            chk("frame_parity", {31'd0, bits[8]}, {31'd0, e[8]});
            chk("frame_stop", {31'd0, bits[9]}, 32'd1);
        end
    endtask

    initial begin : device
        forever begin
            @(negedge clk);
            if (!reset && !tif.tri_c && tif.tri_d && !tif.ps2d_out) begin
                dev_abort = 1'b0;
                run_frame();
            end
        end
    end

    always @(negedge clk) begin
        if (tif.tx_done_tick) begin
            done_cnt++;
            chk("done_vs_idle", {31'd0, tif.tx_idle}, 32'd0);
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        tif.wr_ps2 = 1'b1;
        tif.din    = b;
        @(negedge clk);
        tif.wr_ps2 = 1'b0;
        tif.din    = 8'h00;
    endtask

    task automatic wait_done(input string name);
        int d0;
        int i;
        d0 = done_cnt;
        i  = 0;
        while (done_cnt == d0 && i < 3000) begin
            @(negedge clk);
            i++;
        end
        chk(name, done_cnt - d0, 32'd1);
        @(negedge clk);
        chk({name, "_idle"}, {31'd0, tif.tx_idle}, 32'd1);
    endtask

    task automatic wait_falls(input string name, input int n);
        int i;
        i = 0;
        while (dev_falls < n && i < 3000) begin
            @(negedge clk);
            i++;
        end
        chk(name, {31'd0, (dev_falls >= n)}, 32'd1);
    endtask

    typedef struct packed {
        logic [7:0] b;
        logic       par;
    } vec_t;

    vec_t par_vecs[3] = '{'{8'hFF, 1'b1}, '{8'h00, 1'b1}, '{8'h01, 1'b0}};

    initial begin : main
        int cnt;
        int d0;
        tif.wr_ps2 = 1'b0;
        tif.din    = 8'h00;
        reset      = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_idle", {31'd0, tif.tx_idle}, 32'd1);
        chk("rst_tri_c", {31'd0, tif.tri_c}, 32'd0);
        chk("rst_tri_d", {31'd0, tif.tri_d}, 32'd0);
        chk("rst_ps2c_out", {31'd0, tif.ps2c_out}, 32'd0);
        chk("rst_ps2d_out", {31'd0, tif.ps2d_out}, 32'd0);
        chk("rst_done", {31'd0, tif.tx_done_tick}, 32'd0);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        chk("hold_idle", {31'd0, tif.tx_idle}, 32'd1);
        chk("hold_tri_c", {31'd0, tif.tri_c}, 32'd0);
        chk("hold_tri_d", {31'd0, tif.tri_d}, 32'd0);
        chk("hold_no_done", done_cnt, 32'd0);

        // 0x5A: RTS length, start bit, then the full frame
        exp_q.push_back({1'b1, 8'h5A});
        send(8'h5A);
        cnt = 0;
        while (tif.tri_c && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk("rts_cycles", cnt, RTS);
        chk("start_tri_c", {31'd0, tif.tri_c}, 32'd0);
        chk("start_tri_d", {31'd0, tif.tri_d}, 32'd1);
        chk("start_bit", {31'd0, tif.ps2d_out}, 32'd0);
        wait_done("done_5a");

        foreach (par_vecs[i]) begin
            exp_q.push_back({par_vecs[i].par, par_vecs[i].b});
            send(par_vecs[i].b);
            wait_done("done_par");
        end

        // write during DATA must not disturb the frame in flight
        exp_q.push_back({1'b1, 8'hC5});
        dev_falls = 0;
        send(8'hC5);
        wait_falls("reach_data", 3);
        send(8'h33);
        wait_done("done_c5");
        repeat (300) @(negedge clk);
        chk("ignored_idle", {31'd0, tif.tx_idle}, 32'd1);
        chk("ignored_tri_c", {31'd0, tif.tri_c}, 32'd0);

        // short clock glitches while waiting in START
        exp_q.push_back({1'b1, 8'hA5});
        send(8'hA5);
        cnt = 0;
        while (!(tif.tri_d && !tif.tri_c) && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        chk("reach_start", {31'd0, (cnt < 200)}, 32'd1);
        repeat (10) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            glitch_lo = 1'b1;
            repeat (2) @(negedge clk);
            glitch_lo = 1'b0;
            repeat (8) @(negedge clk);
            chk("glitch_tri_d", {31'd0, tif.tri_d}, 32'd1);
            chk("glitch_bit", {31'd0, tif.ps2d_out}, 32'd0);
        end
        wait_done("done_a5");

        // reset part-way through DATA abandons the frame
        dev_falls = 0;
        send(8'hC3);
        wait_falls("reach_mid", 5);
        repeat (10) @(negedge clk);
        reset     = 1'b1;
        dev_abort = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_tri_c", {31'd0, tif.tri_c}, 32'd0);
        chk("abort_tri_d", {31'd0, tif.tri_d}, 32'd0);
        chk("abort_idle", {31'd0, tif.tx_idle}, 32'd1);
        d0 = done_cnt;
        repeat (200) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 32'd0);

        exp_q.push_back({1'b1, 8'hED});
        send(8'hED);
        wait_done("done_ed");

        repeat (50) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got no completion, expected finish within 60000 cycles");
        $fatal(1, "timeout");
    end
endmodule
